// File: rtl/spi_extcon_slave_pkg.sv
// Shared definitions for the extcon SPI peer receiver: geometry, FSM encoding, beat payload
// and the system/link clock ratio elaboration check. Optional stats: SPI_EXTCON_SLAVE_STAT_EN.
`timescale 1ns/1ps

`ifndef SPI_EXTCON_CHECK_RATIO
`define SPI_EXTCON_CHECK_RATIO(SYS_HZ, SPI_HZ) \
  if (((SYS_HZ) / (SPI_HZ)) < 6) begin : g_ratio_err \
    $error("spi_extcon_slave: system clock must be at least 6x the link clock"); \
  end
`endif

package spi_extcon_slave_pkg;

  localparam int unsigned LANES      = 8;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned WORD_W     = LANES * LANE_W;
  localparam int unsigned BIT_CNT_W  = 3;
  localparam int unsigned FRM_CNT_W  = 16;
  localparam int unsigned WORD_CNT_W = 16;
  localparam int unsigned ERR_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/spi_lane_deser.sv
// One lane's MSB-first deserialiser: shifts the synchronised lane bit in on each enable.
`timescale 1ns/1ps

module spi_lane_deser
  import spi_extcon_slave_pkg::*;
(
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              shift_en,
  input  logic              din,
  output logic [LANE_W-1:0] q
);

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[LANE_W-2:0], din};
    end
  end

endmodule

// File: rtl/spi_extcon_slave.sv
// Extcon SPI peer receiver: oversamples sclk/cs/8 lanes, builds 64-bit words, streams them
// with a last flag one word behind. Optional counters when SPI_EXTCON_SLAVE_STAT_EN is defined.
`timescale 1ns/1ps

module spi_extcon_slave
  import spi_extcon_slave_pkg::*;
#(
  parameter int unsigned pSyS_clk = 125_000_000,
  parameter int unsigned pSPI_clk = 12_500_000,
  parameter logic        pCS_ACT  = 1'b1
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              spi_iclk,
  input  logic              spi_ics,
  input  logic [LANES-1:0]  spi_idata,
  output logic              oval,
  output logic [WORD_W-1:0] odata,
  output logic              olast,
  input  logic              iready,
  output logic              oerr_stb
`ifdef SPI_EXTCON_SLAVE_STAT_EN
  ,
  output logic [FRM_CNT_W-1:0]  ofrm_cnt,
  output logic [WORD_CNT_W-1:0] oword_cnt,
  output logic [ERR_CNT_W-1:0]  oerr_cnt
`endif
);

  `SPI_EXTCON_CHECK_RATIO(pSyS_clk, pSPI_clk)

  logic [2:0]                   sclk_sync;
  logic [1:0]                   cs_sync;
  logic [LANES-1:0]             data_s1;
  logic [LANES-1:0]             data_s2;
  logic                         rise_c;
  logic                         cs_act_c;
  logic                         shift_en_c;

  state_e                       state;
  logic [BIT_CNT_W-1:0]         bitcnt;
  logic                         word_done;
  logic                         pend_vld;
  logic [WORD_W-1:0]            pend_data;
  logic [LANES-1:0][LANE_W-1:0] lane_q;

  logic                         push_c;
  beat_t                        push_beat_c;
  logic                         load_c;
  logic                         overflow_c;
  logic                         partial_c;

  // Two-flop synchronisers; the third sclk flop only serves rise detection.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      sclk_sync <= '0;
      cs_sync   <= {2{~pCS_ACT}};
      data_s1   <= '0;
      data_s2   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_iclk};
      cs_sync   <= {cs_sync[0], spi_ics};
      data_s1   <= spi_idata;
      data_s2   <= data_s1;
    end
  end

  assign rise_c     = sclk_sync[1] & ~sclk_sync[2];
  assign cs_act_c   = (cs_sync[1] == pCS_ACT);
  assign shift_en_c = (state == ST_SHIFT) && cs_act_c && rise_c;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    spi_lane_deser u_lane (
      .iclk     (iclk),
      .irst_n   (irst_n),
      .shift_en (shift_en_c),
      .din      (data_s2[g]),
      .q        (lane_q[g])
    );
  end

  // FLUSH is entered only once any in-flight word has reached the pending register.
  assign partial_c = (state == ST_SHIFT) && !cs_act_c && !word_done && (bitcnt != '0);

  always_comb begin
    push_c      = 1'b0;
    push_beat_c = '0;
    if ((state == ST_SHIFT) && word_done && pend_vld) begin
      push_c      = 1'b1;
      push_beat_c = '{last: 1'b0, data: pend_data};
    end else if ((state == ST_FLUSH) && pend_vld) begin
      push_c      = 1'b1;
      push_beat_c = '{last: 1'b1, data: pend_data};
    end
  end

  assign load_c     = push_c && (!oval || iready);
  assign overflow_c = push_c && oval && !iready;

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state     <= ST_IDLE;
      bitcnt    <= '0;
      word_done <= 1'b0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
    end else begin
      word_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_act_c) begin
            state    <= ST_SHIFT;
            bitcnt   <= '0;
            pend_vld <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (shift_en_c) begin
            bitcnt <= bitcnt + BIT_CNT_W'(1);
            if (bitcnt == BIT_CNT_W'(LANE_W - 1)) begin
              word_done <= 1'b1;
            end
          end
          if (word_done) begin
            pend_data <= lane_q;
            pend_vld  <= 1'b1;
          end
          if (!cs_act_c && !word_done) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          pend_vld <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register; a push that cannot land is dropped and flagged.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      oval     <= 1'b0;
      odata    <= '0;
      olast    <= 1'b0;
      oerr_stb <= 1'b0;
    end else begin
      oerr_stb <= partial_c || overflow_c;
      if (load_c) begin
        oval  <= 1'b1;
        odata <= push_beat_c.data;
        olast <= push_beat_c.last;
      end else if (oval && iready) begin
        oval  <= 1'b0;
        olast <= 1'b0;
      end
    end
  end

`ifdef SPI_EXTCON_SLAVE_STAT_EN
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      ofrm_cnt  <= '0;
      oword_cnt <= '0;
      oerr_cnt  <= '0;
    end else begin
      if ((state == ST_FLUSH) && pend_vld) begin
        ofrm_cnt <= ofrm_cnt + FRM_CNT_W'(1);
      end
      if (load_c) begin
        oword_cnt <= oword_cnt + WORD_CNT_W'(1);
      end
      if (oerr_stb) begin
        oerr_cnt <= oerr_cnt + ERR_CNT_W'(1);
      end
    end
  end
`endif

endmodule
